// File: rtl/me_pkg.sv
// Shared motion-estimation definitions.
// Holds the partition count, the base index of each partition shape inside
// the 41-entry variable-block-size SAD set, the default SAD/MV widths,
// the SAD/MV element types and the search FSM state type.
package me_pkg;

  localparam int unsigned NPART   = 41;

  // Base index of each partition shape inside the 41-entry SAD set
  localparam int unsigned P4X4    = 0;
  localparam int unsigned P8X4    = 16;
  localparam int unsigned P4X8    = 24;
  localparam int unsigned P8X8    = 32;
  localparam int unsigned P16X8   = 36;
  localparam int unsigned P8X16   = 38;
  localparam int unsigned P16X16  = 40;

  localparam int unsigned SAD_BITS = 16;
  localparam int unsigned MV_BITS  = 6;

  typedef logic        [SAD_BITS-1:0] sad_t;
  typedef logic signed [MV_BITS-1:0]  mv_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sad_min_select_if.sv
// Bus between the SAD producer and the minimum selector.
// master (producer side): drives start, sad_valid, sad_in; observes
//   cur_mvx/cur_mvy, busy, result_valid and the best_* result vectors.
// slave  (sad_min_select): the reverse.
interface sad_min_select_if #(
  parameter int unsigned SAD_W = 16,
  parameter int unsigned MV_W  = 6
);
  import me_pkg::*;

  logic                      start;
  logic                      sad_valid;
  logic [NPART*SAD_W-1:0]    sad_in;
  logic signed [MV_W-1:0]    cur_mvx;
  logic signed [MV_W-1:0]    cur_mvy;
  logic                      busy;
  logic                      result_valid;
  logic [NPART*SAD_W-1:0]    best_sad;
  logic [NPART*MV_W-1:0]     best_mvx;
  logic [NPART*MV_W-1:0]     best_mvy;

  modport master (
    output start, sad_valid, sad_in,
    input  cur_mvx, cur_mvy, busy, result_valid, best_sad, best_mvx, best_mvy
  );

  modport slave (
    input  start, sad_valid, sad_in,
    output cur_mvx, cur_mvy, busy, result_valid, best_sad, best_mvx, best_mvy
  );

endinterface

// File: rtl/sad_min_cell.sv
// Single-partition running-minimum register.
// clk, rst (async active-low); init reloads the cell (SAD all ones, MV 0);
// upd_en qualifies sad/mvx/mvy as a candidate; best_* hold the current min.
// Strict less-than: ties keep the earlier candidate, and an all-ones SAD
// can never displace the initial value.
module sad_min_cell #(
  parameter int unsigned SAD_W = 16,
  parameter int unsigned MV_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init,
  input  logic                   upd_en,
  input  logic [SAD_W-1:0]       sad,
  input  logic signed [MV_W-1:0] mvx,
  input  logic signed [MV_W-1:0] mvy,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] best_mvx,
  output logic signed [MV_W-1:0] best_mvy
);

  logic [SAD_W-1:0]       sad_q, sad_d;
  logic signed [MV_W-1:0] mvx_q, mvx_d;
  logic signed [MV_W-1:0] mvy_q, mvy_d;

  always_comb begin
    sad_d = sad_q;
    mvx_d = mvx_q;
    mvy_d = mvy_q;
    if (init) begin
      sad_d = '1;
      mvx_d = '0;
      mvy_d = '0;
    end else if (upd_en && (sad < sad_q)) begin
      sad_d = sad;
      mvx_d = mvx;
      mvy_d = mvy;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sad_q <= '1;
      mvx_q <= '0;
      mvy_q <= '0;
    end else begin
      sad_q <= sad_d;
      mvx_q <= mvx_d;
      mvy_q <= mvy_d;
    end
  end

  assign best_sad = sad_q;
  assign best_mvx = mvx_q;
  assign best_mvy = mvy_q;

endmodule

// File: rtl/sad_min_select.sv
// Full-search minimum selector for 41 variable-block-size SADs of a 16x16
// macroblock. Walks the (2*RANGE+1)^2 window in raster order (y outer,
// x inner, from -RANGE), keeping per partition the smallest SAD and its MV.
// Ports: clk; rst (async active-low); bus (slave modport): start,
//   sad_valid, sad_in in; cur_mvx/cur_mvy (position of the next valid),
//   busy, result_valid (one-cycle done pulse), best_sad/best_mvx/best_mvy out.
module sad_min_select
  import me_pkg::*;
#(
  parameter int unsigned SAD_W = 16,
  parameter int unsigned RANGE = 8,
  parameter int unsigned MV_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  sad_min_select_if.slave  bus
);

  localparam int                     SRANGE = int'(RANGE);
  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SRANGE);
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SRANGE);

  state_e                 state_q, state_d;
  logic signed [MV_W-1:0] mvx_q, mvx_d;
  logic signed [MV_W-1:0] mvy_q, mvy_d;
  logic                   result_valid_q, result_valid_d;
  logic                   upd_en;

  logic [NPART*SAD_W-1:0] best_sad_w;
  logic [NPART*MV_W-1:0]  best_mvx_w;
  logic [NPART*MV_W-1:0]  best_mvy_w;

  // start outranks a coincident sad_valid, so that sample is dropped
  assign upd_en = (state_q == ST_SEARCH) && bus.sad_valid && !bus.start;

  always_comb begin
    state_d        = state_q;
    mvx_d          = mvx_q;
    mvy_d          = mvy_q;
    result_valid_d = 1'b0;
    if (bus.start) begin
      state_d = ST_SEARCH;
      mvx_d   = MV_MIN;
      mvy_d   = MV_MIN;
    end else if (upd_en) begin
      if (mvx_q == MV_MAX) begin
        mvx_d = MV_MIN;
        if (mvy_q == MV_MAX) begin
          // last position: counters return to the window origin
          state_d        = ST_DONE;
          result_valid_d = 1'b1;
          mvy_d          = MV_MIN;
        end else begin
          mvy_d = mvy_q + MV_W'(1);
        end
      end else begin
        mvx_d = mvx_q + MV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      mvx_q          <= MV_MIN;
      mvy_q          <= MV_MIN;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mvx_q          <= mvx_d;
      mvy_q          <= mvy_d;
      result_valid_q <= result_valid_d;
    end
  end

  for (genvar p = 0; p < NPART; p++) begin : g_cell
    sad_min_cell #(
      .SAD_W (SAD_W),
      .MV_W  (MV_W)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .init     (bus.start),
      .upd_en   (upd_en),
      .sad      (bus.sad_in[p*SAD_W +: SAD_W]),
      .mvx      (mvx_q),
      .mvy      (mvy_q),
      .best_sad (best_sad_w[p*SAD_W +: SAD_W]),
      .best_mvx (best_mvx_w[p*MV_W +: MV_W]),
      .best_mvy (best_mvy_w[p*MV_W +: MV_W])
    );
  end

  assign bus.cur_mvx      = mvx_q;
  assign bus.cur_mvy      = mvy_q;
  assign bus.busy         = (state_q == ST_SEARCH);
  assign bus.result_valid = result_valid_q;
  assign bus.best_sad     = best_sad_w;
  assign bus.best_mvx     = best_mvx_w;
  assign bus.best_mvy     = best_mvy_w;

endmodule
